// File: rtl/uart_rx_engine.sv
// UART receiver: pad synchroniser, 3-sample majority vote per bit, frame FSM with
// parity/framing/break detection and a single-word valid/ready holding register.
module uart_rx_engine #(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     rx_en,
    input  logic                     uartn_rxd,
    input  logic                     baud_tick,
    input  logic [3:0]               cfg_data_bits,
    input  logic                     cfg_parity_en,
    input  logic                     cfg_parity_odd,
    input  logic                     cfg_stop2,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     rx_parity_err,
    output logic                     rx_frame_err,
    output logic                     rx_break,
    output logic                     rx_overrun,
    output logic                     rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_BRKWAIT = 3'd5;

    localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_VOTE = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0]   sync_reg;
    logic                     rxd_s;
    logic [2:0]               state_reg, state_next;
    logic [TW-1:0]            tick_cnt_reg, tick_cnt_next;
    logic [3:0]               bit_cnt_reg, bit_cnt_next;
    logic [1:0]               samp_reg;
    logic [MAX_DATA_BITS-1:0] data_reg, data_next;
    logic                     perr_reg, ferr_reg, any_one_reg;
    logic [3:0]               nbits_reg, nbits_clamped;
    logic                     par_en_reg, par_odd_reg, stop2_reg;
    logic [MAX_DATA_BITS-1:0] rx_data_reg;
    logic                     rx_valid_reg, rx_parity_err_reg, rx_frame_err_reg;
    logic                     rx_break_reg, rx_overrun_reg;

    logic vote, tick_vote, tick_end, start_detect, frame_done, done_ferr, done_brk, par_exp;

    assign rxd_s        = sync_reg[SYNC_STAGES-1];
    assign vote         = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rxd_s) | (samp_reg[1] & rxd_s);
    assign tick_vote    = baud_tick && (tick_cnt_reg == TICK_VOTE);
    assign tick_end     = baud_tick && (tick_cnt_reg == TICK_LAST);
    assign start_detect = rx_en && (state_reg == S_IDLE) && !rxd_s;
    assign par_exp      = (^data_reg) ^ par_odd_reg;

    // The frame completes on the vote of the last stop bit, not at the end of that bit.
    assign frame_done = rx_en && (state_reg == S_STOP) && tick_vote && (!stop2_reg || bit_cnt_reg[0]);
    assign done_ferr  = ferr_reg | ~vote;
    assign done_brk   = ~(any_one_reg | vote);

    always_comb begin
        nbits_clamped = cfg_data_bits;
        if (cfg_data_bits < 4'd5)
            nbits_clamped = 4'd5;
        else if (cfg_data_bits > 4'(MAX_DATA_BITS))
            nbits_clamped = 4'(MAX_DATA_BITS);
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_DATA_BITS; gi++) begin : g_data
            assign data_next[gi] = (bit_cnt_reg == 4'(gi)) ? vote : data_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        tick_cnt_next = tick_cnt_reg;
        if (state_reg != S_IDLE && baud_tick)
            tick_cnt_next = (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + TW'(1);
        if (!rx_en) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_next    = S_START;
                        tick_cnt_next = '0;
                    end
                end
                S_START: begin
                    if (tick_vote && vote) begin
                        state_next = S_IDLE;
                    end else if (tick_end) begin
                        state_next   = S_DATA;
                        bit_cnt_next = 4'd0;
                    end
                end
                S_DATA: begin
                    if (tick_end) begin
                        if (bit_cnt_reg == nbits_reg - 4'd1) begin
                            bit_cnt_next = 4'd0;
                            state_next   = par_en_reg ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick_end)
                        state_next = S_STOP;
                end
                S_STOP: begin
                    if (frame_done)
                        state_next = done_brk ? S_BRKWAIT : S_IDLE;
                    else if (tick_end)
                        bit_cnt_next = 4'd1;
                end
                S_BRKWAIT: begin
                    if (rxd_s)
                        state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            sync_reg          <= '1;
            state_reg         <= S_IDLE;
            tick_cnt_reg      <= '0;
            bit_cnt_reg       <= '0;
            samp_reg          <= '0;
            data_reg          <= '0;
            perr_reg          <= 1'b0;
            ferr_reg          <= 1'b0;
            any_one_reg       <= 1'b0;
            nbits_reg         <= 4'd5;
            par_en_reg        <= 1'b0;
            par_odd_reg       <= 1'b0;
            stop2_reg         <= 1'b0;
            rx_data_reg       <= '0;
            rx_valid_reg      <= 1'b0;
            rx_parity_err_reg <= 1'b0;
            rx_frame_err_reg  <= 1'b0;
            rx_break_reg      <= 1'b0;
            rx_overrun_reg    <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[SYNC_STAGES-2:0], uartn_rxd};
            state_reg      <= state_next;
            tick_cnt_reg   <= tick_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            rx_overrun_reg <= 1'b0;

            if (start_detect) begin
                nbits_reg   <= nbits_clamped;
                par_en_reg  <= cfg_parity_en;
                par_odd_reg <= cfg_parity_odd;
                stop2_reg   <= cfg_stop2;
                data_reg    <= '0;
                perr_reg    <= 1'b0;
                ferr_reg    <= 1'b0;
                any_one_reg <= 1'b0;
            end

            if (baud_tick && tick_cnt_reg == TICK_S0)
                samp_reg[0] <= rxd_s;
            if (baud_tick && tick_cnt_reg == TICK_S1)
                samp_reg[1] <= rxd_s;

            if (tick_vote) begin
                case (state_reg)
                    S_DATA: begin
                        data_reg    <= data_next;
                        any_one_reg <= any_one_reg | vote;
                    end
                    S_PARITY: begin
                        perr_reg    <= (vote != par_exp);
                        any_one_reg <= any_one_reg | vote;
                    end
                    S_STOP: begin
                        ferr_reg    <= done_ferr;
                        any_one_reg <= any_one_reg | vote;
                    end
                    default: ;
                endcase
            end

            // A completion that coincides with an accept replaces the held word seamlessly.
            if (frame_done) begin
                if (!rx_valid_reg || rx_ready) begin
                    rx_data_reg       <= data_reg;
                    rx_parity_err_reg <= perr_reg;
                    rx_frame_err_reg  <= done_ferr;
                    rx_break_reg      <= done_brk;
                    rx_valid_reg      <= 1'b1;
                end else begin
                    rx_overrun_reg <= 1'b1;
                end
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data       = rx_data_reg;
    assign rx_valid      = rx_valid_reg;
    assign rx_parity_err = rx_parity_err_reg;
    assign rx_frame_err  = rx_frame_err_reg;
    assign rx_break      = rx_break_reg;
    assign rx_overrun    = rx_overrun_reg;
    assign rx_busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: directed frames built bit by bit, expected words derived
// from the line levels by a frame-level model, checked every cycle rx_valid is high.
module tb_uart_rx_engine;

    localparam int OS  = 16;
    localparam int DIV = 4;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } exp_t;

    logic       pclk = 1'b0;
    logic       preset, rx_en, uartn_rxd, baud_tick, rx_ready;
    logic [3:0] cfg_data_bits;
    logic       cfg_parity_en, cfg_parity_odd, cfg_stop2;
    logic [8:0] rx_data;
    logic       rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ovr_cnt  = 0;
    int   acc_cnt  = 0;
    logic ready_level;
    exp_t exp_q[$];
    exp_t last_seen, last_acc;
    logic last_seen_valid;

    always #5 pclk = ~pclk;

    uart_rx_engine dut (
        .pclk(pclk), .preset(preset), .rx_en(rx_en), .uartn_rxd(uartn_rxd),
        .baud_tick(baud_tick), .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err), .rx_break(rx_break), .rx_overrun(rx_overrun),
        .rx_busy(rx_busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Expected word from the levels actually driven on the line.
    function automatic exp_t model(input logic [12:0] lb, input int len, input int eff, input bit pe, input bit odd);
        exp_t e;
        bit   allz;
        e = '0;
        for (int i = 0; i < eff; i++) e.d[i] = lb[1+i];
        e.pe = pe && (lb[1+eff] != ((^e.d) ^ odd));
        allz = (e.d == 9'd0) && !(pe && lb[1+eff]);
        for (int k = 1 + eff + int'(pe); k < len; k++) begin
            if (!lb[k]) e.fe = 1'b1;
            else        allz = 1'b0;
        end
        e.brk = allz;
        return e;
    endfunction

    task automatic compare_loop();
        forever begin
            @(negedge pclk);
            last_seen_valid = rx_valid;
            last_seen       = {rx_data, rx_parity_err, rx_frame_err, rx_break};
            if (!preset) begin
                if (rx_overrun) ovr_cnt++;
                if (rx_valid) begin
                    if (exp_q.size() == 0)
                        check("spurious_valid", {23'd0, rx_data}, 32'hFFFF_FFFF);
                    else
                        check("word", 32'(last_seen), 32'(exp_q[0]));
                end
            end
        end
    endtask

    task automatic pop_loop();
        forever begin
            @(posedge pclk);
            if (!preset && last_seen_valid && rx_ready && exp_q.size() > 0) begin
                last_acc = last_seen;
                acc_cnt++;
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic one_tick(input bit pulse);
        for (int i = 0; i < DIV; i++) begin
            baud_tick = (i == DIV - 1);
            rx_ready  = (i == DIV - 1 && pulse) ? 1'b1 : ready_level;
            @(negedge pclk);
        end
        baud_tick = 1'b0;
        rx_ready  = ready_level;
    endtask

    task automatic idle_bits(input int n);
        uartn_rxd = 1'b1;
        repeat (n * OS) one_tick(1'b0);
    endtask

    task automatic send_frame(input logic [8:0] data, input logic [3:0] nb_cfg, input bit pe,
                              input bit odd, input bit st2, input bit pflip,
                              input logic [1:0] stop_zero, input bit push, input int rdy_tick);
        logic [12:0] lb;
        int          len, eff, t;
        logic        p;
        eff = (nb_cfg < 5) ? 5 : ((nb_cfg > 9) ? 9 : int'(nb_cfg));
        cfg_data_bits = nb_cfg; cfg_parity_en = pe; cfg_parity_odd = odd; cfg_stop2 = st2;
        lb = '0; len = 0; p = odd ^ pflip;
        lb[len++] = 1'b0;
        for (int i = 0; i < eff; i++) begin
            lb[len++] = data[i];
            p = p ^ data[i];
        end
        if (pe) lb[len++] = p;
        lb[len++] = !stop_zero[0];
        if (st2) lb[len++] = !stop_zero[1];
        if (push) exp_q.push_back(model(lb, len, eff, pe, odd));
        t = 0;
        for (int b = 0; b < len; b++) begin
            uartn_rxd = lb[b];
            repeat (OS) begin
                one_tick(t == rdy_tick);
                t++;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge pclk);
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovr0, acc0;
        preset = 1'b1; rx_en = 1'b0; uartn_rxd = 1'b1; baud_tick = 1'b0;
        ready_level = 1'b1; rx_ready = 1'b1;
        cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
        last_seen = '0; last_acc = '0; last_seen_valid = 1'b0;
        fork
            compare_loop();
            pop_loop();
        join_none
        repeat (3) @(negedge pclk);
        check("reset_data", {23'd0, rx_data}, 0);
        check("reset_valid", {31'd0, rx_valid}, 0);
        check("reset_flags", {28'd0, rx_parity_err, rx_frame_err, rx_break, rx_overrun}, 0);
        check("reset_busy", {31'd0, rx_busy}, 0);
        preset = 1'b0; rx_en = 1'b1;
        idle_bits(2);

        // 8N1 0xA5, consumer always ready
        acc0 = acc_cnt;
        send_frame(9'h0A5, 4'd8, 0, 0, 0, 0, 2'b00, 1, -1);
        idle_bits(1);
        drain();
        check("t1_data", {23'd0, last_acc.d}, 32'h0A5);
        check("t1_flags", {29'd0, last_acc.pe, last_acc.fe, last_acc.brk}, 0);
        check("t1_one_word", acc_cnt - acc0, 1);

        // 7E2 0x41 with the parity bit inverted
        send_frame(9'h041, 4'd7, 1, 0, 1, 1, 2'b00, 1, -1);
        idle_bits(1);
        drain();
        check("t2_data", {23'd0, last_acc.d}, 32'h041);
        check("t2_parity_err", {31'd0, last_acc.pe}, 1);

        // data-bit count clamping at both ends
        send_frame(9'h015, 4'd2, 0, 0, 0, 0, 2'b00, 1, -1);
        idle_bits(1);
        drain();
        check("clamp_low", {23'd0, last_acc.d}, 32'h015);
        send_frame(9'h1A5, 4'd15, 1, 1, 0, 0, 2'b00, 1, -1);
        idle_bits(1);
        drain();
        check("clamp_high", {23'd0, last_acc.d}, 32'h1A5);
        check("clamp_high_par", {31'd0, last_acc.pe}, 0);

        // glitch start, then a good frame
        uartn_rxd = 1'b0;
        repeat (4) one_tick(1'b0);
        idle_bits(2);
        check("t3_idle_busy", {31'd0, rx_busy}, 0);
        send_frame(9'h03C, 4'd8, 0, 0, 0, 0, 2'b00, 1, -1);
        idle_bits(1);
        drain();
        check("t3_data", {23'd0, last_acc.d}, 32'h03C);

        // stop bit low: framing error only
        send_frame(9'h03C, 4'd8, 0, 0, 0, 0, 2'b01, 1, -1);
        idle_bits(2);
        drain();
        check("t4_frame_err", {31'd0, last_acc.fe}, 1);
        check("t4_no_break", {31'd0, last_acc.brk}, 0);

        // 12 bit-times of zero: break, held until the line returns high
        send_frame(9'h000, 4'd8, 0, 0, 0, 0, 2'b01, 1, -1);
        repeat (2 * OS) one_tick(1'b0);
        drain();
        check("t4_break", {30'd0, last_acc.brk, last_acc.fe}, 3);
        check("t4_brkwait_busy", {31'd0, rx_busy}, 1);
        uartn_rxd = 1'b1;
        repeat (6) @(negedge pclk);
        check("t4_brk_exit", {31'd0, rx_busy}, 0);
        idle_bits(1);

        // overrun, then a completion coinciding with an accept
        ready_level = 1'b0; rx_ready = 1'b0;
        ovr0 = ovr_cnt;
        send_frame(9'h011, 4'd8, 0, 0, 0, 0, 2'b00, 1, -1);
        idle_bits(1);
        send_frame(9'h022, 4'd8, 0, 0, 0, 0, 2'b00, 0, -1);
        idle_bits(1);
        check("t5_overrun", ovr_cnt - ovr0, 1);
        check("t5_held", {22'd0, rx_valid, rx_data}, 32'h211);
        send_frame(9'h022, 4'd8, 0, 0, 0, 0, 2'b00, 1, 9 * OS + OS / 2 + 1);
        idle_bits(1);
        check("t5_no_overrun", ovr_cnt - ovr0, 1);
        check("t5_loaded", {22'd0, rx_valid, rx_data}, 32'h222);
        ready_level = 1'b1; rx_ready = 1'b1;
        drain();

        // rx_en dropped in data bit 3
        cfg_data_bits = 4'd8;
        uartn_rxd = 1'b0;
        repeat (OS) one_tick(1'b0);
        for (int b = 0; b < 3; b++) begin
            uartn_rxd = b[0];
            repeat (OS) one_tick(1'b0);
        end
        uartn_rxd = 1'b1;
        repeat (OS / 2) one_tick(1'b0);
        rx_en = 1'b0;
        @(negedge pclk);
        check("t6_abort_busy", {31'd0, rx_busy}, 0);
        idle_bits(1);
        rx_en = 1'b1;
        idle_bits(2);

        // reset mid-frame with a word held
        ready_level = 1'b0; rx_ready = 1'b0;
        send_frame(9'h05A, 4'd8, 0, 0, 0, 0, 2'b00, 1, -1);
        idle_bits(1);
        uartn_rxd = 1'b0;
        repeat (OS + OS / 2) one_tick(1'b0);
        check("t6_pre_reset", {22'd0, rx_busy, rx_data}, 32'h25A);
        preset = 1'b1;
        exp_q.delete();
        @(negedge pclk);
        check("t6_reset_outputs", {23'd0, rx_data, rx_valid, rx_parity_err, rx_frame_err,
                                   rx_break, rx_overrun, rx_busy}, 0);
        preset = 1'b0;
        uartn_rxd = 1'b1; ready_level = 1'b1; rx_ready = 1'b1;
        idle_bits(2);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
